// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//   Receive side of the 4-slot TDM link. Takes one WIDTH-bit sample per clock
//   (slot order 0,1,2,3,0,...) and de-interleaves it into four registered
//   channel outputs. It can align to an optional frame-sync marker, flags
//   misaligned markers, and pulses frame_valid when a full frame is delivered.
//
// Parameters
//   WIDTH     : bits per slot sample / channel output
//   FREE_RUN  : 1 = aligned out of reset (first sample is slot 0)
//               0 = hunt for sync before capturing anything
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-low reset
//   in           : serial slot sample for this cycle
//   sync         : frame marker, high alongside a slot-0 sample
//   out0..out3   : channel values of the last complete frame
//   frame_valid  : one-cycle pulse when out0..out3 load a new frame
//   locked       : aligned and capturing
//   sync_err     : one-cycle pulse when sync arrives at a slot other than 0
// ---------------------------------------------------------------------------
module tdm_demux #(
  parameter int WIDTH    = 2,
  parameter bit FREE_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam state_e RST_STATE = FREE_RUN ? LOCKED : HUNT;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] s0_q, s0_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    out3_d  = out3_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      HUNT: begin
        if (sync) begin
          s0_d    = in;
          cnt_d   = 2'd1;
          state_d = LOCKED;
        end
      end
      default: begin
        if (sync && (cnt_q != 2'd0)) begin
          // Misaligned marker: drop the partial frame and restart at slot 0
          // with the current sample. This also covers a marker on slot 3,
          // so the outputs never load a frame that straddles the marker.
          err_d = 1'b1;
          s0_d  = in;
          cnt_d = 2'd1;
        end else begin
          // A missing marker on slot 0 is tolerated: keep free-wheeling.
          case (cnt_q)
            2'd0: s0_d = in;
            2'd1: s1_d = in;
            2'd2: s2_d = in;
            default: begin
              out0_d = s0_q;
              out1_d = s1_q;
              out2_d = s2_q;
              out3_d = in;
              fv_d   = 1'b1;
            end
          endcase
          cnt_d = cnt_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_STATE;
      cnt_q   <= 2'd0;
      out0_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      out3_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      out3_q  <= out3_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  // Shadow slots need no reset: the counter restarts at slot 0 after reset,
  // so every shadow is rewritten before it can reach an output.
  always_ff @(posedge clk) begin
    s0_q <= s0_d;
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  logic       clk;
  logic       rst;
  logic [1:0] in_a, in_b;
  logic       sync_a, sync_b;
  logic [1:0] o0_a, o1_a, o2_a, o3_a;
  logic [1:0] o0_b, o1_b, o2_b, o3_b;
  logic       fv_a, fv_b, lk_a, lk_b, err_a, err_b;

  // A: free-running instance, B: sync-hunting instance
  tdm_demux #(.WIDTH(2), .FREE_RUN(1'b1)) u_a (
    .clk(clk), .rst(rst), .in(in_a), .sync(sync_a),
    .out0(o0_a), .out1(o1_a), .out2(o2_a), .out3(o3_a),
    .frame_valid(fv_a), .locked(lk_a), .sync_err(err_a)
  );

  tdm_demux #(.WIDTH(2), .FREE_RUN(1'b0)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .sync(sync_b),
    .out0(o0_b), .out1(o1_b), .out2(o2_b), .out3(o3_b),
    .frame_valid(fv_b), .locked(lk_b), .sync_err(err_b)
  );

  wire [7:0] outs_a = {o0_a, o1_a, o2_a, o3_a};
  wire [7:0] outs_b = {o0_b, o1_b, o2_b, o3_b};

  int n_chk  = 0;
  int n_fail = 0;
  int errs_a = 0;
  int errs_b = 0;
  int err_exp_a = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] last_a;
  logic       b_lock_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every frame_valid pops the frame queued when its slots
  // were driven; pulses with nothing queued are errors.
  always @(negedge clk) begin
    if (fv_a) begin
      if (qa.size() == 0) chk("fv_a_unexpected", 32'(fv_a), 32'(0));
      else chk("frame_a", 32'(outs_a), 32'(qa.pop_front()));
    end
    if (fv_b) begin
      if (qb.size() == 0) chk("fv_b_unexpected", 32'(fv_b), 32'(0));
      else chk("frame_b", 32'(outs_b), 32'(qb.pop_front()));
    end
    if (fv_a && err_a) chk("fv_err_a_same", 32'(1), 32'(0));
    if (fv_b && err_b) chk("fv_err_b_same", 32'(1), 32'(0));
    errs_a += int'(err_a);
    errs_b += int'(err_b);
  end

  task automatic cyc(input logic [1:0] ia, input logic sa,
                     input logic [1:0] ib, input logic sb);
    in_a = ia; sync_a = sa; in_b = ib; sync_b = sb;
    @(posedge clk); #1;
  endtask

  // One aligned frame on both instances; B expects output only once locked.
  task automatic frm(input logic [7:0] fa, input logic [7:0] fb, input logic sb0);
    logic sa0;
    sa0 = 1'($urandom_range(0, 1));
    if (sb0) b_lock_exp = 1'b1;
    qa.push_back(fa);
    if (b_lock_exp) qb.push_back(fb);
    cyc(fa[7:6], sa0, fb[7:6], sb0);
    chk("locked_b", 32'(lk_b), 32'(b_lock_exp));
    cyc(fa[5:4], 1'b0, fb[5:4], 1'b0);
    cyc(fa[3:2], 1'b0, fb[3:2], 1'b0);
    chk("fv_a_early", 32'(fv_a), 32'(0));
    cyc(fa[1:0], 1'b0, fb[1:0], 1'b0);
    chk("fv_a", 32'(fv_a), 32'(1));
    chk("fv_b", 32'(fv_b), 32'(b_lock_exp));
    chk("err_a_clean", 32'(err_a), 32'(0));
    last_a = fa;
  endtask

  // Marker on A at slot at_slot (2 or 3); the marked sample starts a new frame.
  task automatic misalign(input int at_slot);
    logic [7:0] f;
    f = 8'($urandom);
    for (int i = 0; i < at_slot; i++) cyc(2'($urandom), 1'b0, 2'd3, 1'b0);
    qa.push_back(f);
    err_exp_a++;
    cyc(f[7:6], 1'b1, 2'd3, 1'b0);
    chk("serr_a", 32'(err_a), 32'(1));
    chk("fv_a_misal", 32'(fv_a), 32'(0));
    chk("hold_a", 32'(outs_a), 32'(last_a));
    cyc(f[5:4], 1'b0, 2'd3, 1'b0);
    chk("serr_a_pulse", 32'(err_a), 32'(0));
    cyc(f[3:2], 1'b0, 2'd3, 1'b0);
    cyc(f[1:0], 1'b0, 2'd3, 1'b0);
    chk("fv_a_realign", 32'(fv_a), 32'(1));
    last_a = f;
  endtask

  initial begin
    rst = 1'b0; b_lock_exp = 1'b0; last_a = 8'h00;
    in_a = 2'd0; in_b = 2'd0; sync_a = 1'b0; sync_b = 1'b0;

    // Reset with random input
    cyc(2'($urandom), 1'b0, 2'($urandom), 1'b0);
    cyc(2'($urandom), 1'b0, 2'($urandom), 1'b0);
    chk("rst_outs_a", 32'(outs_a), 32'(0));
    chk("rst_outs_b", 32'(outs_b), 32'(0));
    chk("rst_fv", 32'({fv_a, fv_b}), 32'(0));
    chk("rst_err", 32'({err_a, err_b}), 32'(0));
    chk("rst_locked_a", 32'(lk_a), 32'(1));
    chk("rst_locked_b", 32'(lk_b), 32'(0));

    // Free-run loopback on A; B sees 3s with no marker and stays hunting
    rst = 1'b1;
    frm({2'd1, 2'd2, 2'd3, 2'd0}, 8'hFF, 1'b0);
    chk("first_frame_a", 32'(outs_a), 32'({2'd1, 2'd2, 2'd3, 2'd0}));
    for (int i = 0; i < 50; i++) frm(8'($urandom), 8'hFF, 1'b0);
    chk("hunt_locked_b", 32'(lk_b), 32'(0));
    chk("hunt_outs_b", 32'(outs_b), 32'(0));

    // Misaligned markers on A
    misalign(2);
    misalign(3);

    // B acquires lock on its first marker
    frm(8'($urandom), {2'd2, 2'd1, 2'd0, 2'd3}, 1'b1);
    chk("hunt_frame_b", 32'(outs_b), 32'({2'd2, 2'd1, 2'd0, 2'd3}));
    for (int i = 0; i < 6; i++) frm(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Reset after slot 1 of a frame
    cyc(2'd1, 1'b0, 2'd1, 1'b1);
    cyc(2'd2, 1'b0, 2'd2, 1'b0);
    rst = 1'b0;
    cyc(2'd0, 1'b0, 2'd0, 1'b0);
    chk("midrst_outs_a", 32'(outs_a), 32'(0));
    chk("midrst_outs_b", 32'(outs_b), 32'(0));
    chk("midrst_locked_b", 32'(lk_b), 32'(0));
    rst = 1'b1;
    b_lock_exp = 1'b0;
    frm({2'd3, 2'd2, 2'd1, 2'd0}, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
    chk("midrst_frame_a", 32'(outs_a), 32'({2'd3, 2'd2, 2'd1, 2'd0}));
    chk("midrst_frame_b", 32'(outs_b), 32'({2'd3, 2'd2, 2'd1, 2'd0}));
    cyc(2'd0, 1'b0, 2'd0, 1'b0);

    @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'(0));
    chk("qb_drained", 32'(qb.size()), 32'(0));
    chk("serr_count_a", 32'(errs_a), 32'(err_exp_a));
    chk("serr_count_b", 32'(errs_b), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side counterpart of the 4-slot time-division multiplexer. It takes the serial slot stream (one WIDTH-bit sample per clock, slots in order 0,1,2,3,0,…) and de-interleaves it back into four parallel channel outputs. It can align to an optional frame-sync marker, detect misaligned markers, and flag each completed frame. It sits directly on the output of the TDM mux, or at the far end of any link carrying that stream.

## Interface
Parameters:
- WIDTH, 2, bit width of each slot sample and of each channel output.
- FREE_RUN, 1, when 1 the block is locked out of reset and treats the first post-reset sample as slot 0. When 0 it hunts for `sync` before capturing anything.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in  input  WIDTH  serial slot sample for the current cycle.
- sync  input  1  frame marker; high in the same cycle as a slot-0 sample.
- out0..out3  output  WIDTH each  registered channel values from the last complete frame.
- frame_valid  output  1  one-cycle pulse when out0..out3 take a new frame.
- locked  output  1  block is aligned and capturing.
- sync_err  output  1  one-cycle pulse when `sync` arrives at a slot other than 0.

## Operation
- State machine:
  - HUNT: nothing is captured and the slot counter is held at 0. When `sync` = 1, `in` is captured as slot 0, the counter becomes 1, and the state moves to LOCKED.
  - LOCKED: every cycle, `in` is captured into the slot given by the 2-bit counter, and the counter increments (3 wraps to 0).
- Shadow registers s0..s2 hold slots 0–2. On the slot-3 cycle, all four outputs load together: out0 <= s0, out1 <= s1, out2 <= s2, out3 <= in. frame_valid pulses on that same edge.
- Sync handling in LOCKED:
  - `sync` = 1 with counter = 0: normal; no error.
  - `sync` = 0 with counter = 0: tolerated; the block free-wheels.
  - `sync` = 1 with counter != 0: the realign rule applies.
- Realign rule:
  - sync_err pulses.
  - The partial frame is discarded: outputs hold and no frame_valid is raised.
  - The current `in` is captured as slot 0 and the counter becomes 1.
  - locked stays 1.
- A misaligned `sync` on the slot-3 cycle is still an error. That sample becomes slot 0, outputs do not load, and no frame_valid pulse occurs.
- Outputs hold their last frame value between frames and while in HUNT.
- No arithmetic beyond the 2-bit wrapping counter. Samples are stored unmodified, WIDTH bits each.

## Timing
- Reset values:
  - out0..out3 = 0, frame_valid = 0, sync_err = 0.
  - counter = 0.
  - State = LOCKED and locked = 1 if FREE_RUN = 1; otherwise state = HUNT and locked = 0.
- Reset asserted mid-frame: all shadow data is discarded. Capture restarts from slot 0 on the first edge after rst returns high.
- Latency:
  - The slot-0 sample taken at edge N appears on out0 after edge N+3, together with frame_valid.
  - The slot-3 sample appears on out3 one edge after it is present on `in`.
- frame_valid and sync_err are high for exactly one cycle per event and never high in the same cycle.
- Throughput: one frame every 4 clocks with no bubbles. frame_valid is periodic with period 4 while aligned.
- locked rises on the edge that captures the first `sync` in HUNT. It only falls through reset.

## Test plan
- Reset check: hold rst = 0 for 2 edges with random `in` → out0..out3 = 0, frame_valid = 0, sync_err = 0. locked = 1 when FREE_RUN = 1, 0 when FREE_RUN = 0.
- Free-run loopback (FREE_RUN = 1): drive the TDM mux output into `in` with mux inputs 1,2,3,0, released from reset together → after 4 edges out0..out3 = 1,2,3,0 and frame_valid pulses every 4th cycle. Change the mux inputs randomly per frame over 50 frames → each frame matches the inputs sampled in its own slots.
- Hunt (FREE_RUN = 0): stream 3,3,3 with sync = 0 → locked = 0 and outputs stay 0. Then send sync = 1 with samples 2,1,0,3 → locked = 1 on the first edge, and 4 edges later outputs = 2,1,0,3 with one frame_valid pulse.
- Misaligned sync: while locked, assert `sync` at slot 2 → sync_err pulses once, no frame_valid for that frame, outputs hold the previous frame. The next frame starts from the sync sample.
- Sync at slot 3: assert `sync` on a slot-3 cycle → sync_err = 1 and frame_valid = 0 in that cycle, and outputs do not change.
- Reset mid-frame: assert rst after slot 1 of a frame, release, then send a clean frame 3,2,1,0 → outputs = 3,2,1,0 with no stale slot data and no sync_err.
